datapath1_ctrl: RTL and testbench
=================================

Name: datapath1_ctrl

Overview:
Instruction issue controller that sits in front of datapath1 and drives its control inputs (register addresses, ALUSrc, AddSub, immediate) plus a write enable for the regfile.
Accepts 32-bit instructions over a valid/ready handshake and executes each in one EXEC cycle.
Captures carry/overflow status returned by the datapath.
Halts on an illegal opcode, and on overflow when trapping is enabled.

Parameters:
TRAP_ON_OVF, 1, 1 = enter HALT when an arithmetic instruction overflows; 0 = record only.
CNT_W, 16, width of the retired-instruction counter.

Ports:
i_CLK  in  1  clock, rising edge.
i_RST  in  1  synchronous active-high reset; shared with datapath1.
i_Instr  in  32  instruction word.
i_Valid  in  1  i_Instr valid.
o_Ready  out  1  controller can accept an instruction.
i_Clear  in  1  clears sticky flags and exits HALT.
i_Cout  in  1  datapath carry-out.
i_Overflow  in  1  datapath overflow.
o_RA0  out  5  datapath read address 0 (rs).
o_RA1  out  5  datapath read address 1 (rt).
o_WA  out  5  datapath write address (rd).
o_Im  out  16  immediate, sign-extended by datapath.
o_ALUSrc  out  1  1 = immediate operand.
o_AddSub  out  1  1 = subtract.
o_WE  out  1  regfile write enable.
o_Carry  out  1  last captured carry.
o_Ovf  out  1  last captured overflow.
o_OvfSticky  out  1  OR of all overflows since reset/clear.
o_Halt  out  1  controller halted.
o_Illegal  out  1  halt caused by illegal opcode.
o_Retired  out  CNT_W  count of executed instructions.

Behaviour:
- Instruction format:
  - [31:29] opcode: 000 NOP, 001 ADD, 010 SUB, 011 ADDI, 100 SUBI; 101–111 are illegal.
  - [25:21] rd, [20:16] rs, [15:11] rt, [15:0] imm.
- Instruction register (IR) is loaded on accept.
- Decoded outputs are combinational from IR:
  - o_RA0 = rs, o_RA1 = rt, o_WA = rd, o_Im = imm.
  - o_ALUSrc = 1 for ADDI/SUBI.
  - o_AddSub = 1 for SUB/SUBI.
- o_WE = 1 only in EXEC with a legal non-NOP opcode; it is never 1 in any other state.
- States: IDLE, EXEC, HALT.
  - IDLE: o_Ready = 1. On i_Valid & o_Ready at the edge, load IR and go to EXEC.
  - EXEC: o_Ready = 0; lasts exactly 1 cycle.
    - Legal opcode: o_Retired += 1 and return to IDLE.
    - Arithmetic opcode: at the closing edge, capture o_Carry = i_Cout and o_Ovf = i_Overflow; o_OvfSticky |= i_Overflow. NOP leaves all flags unchanged.
    - Illegal opcode: o_WE = 0, no retire; go to HALT and set o_Illegal.
    - TRAP_ON_OVF = 1 and i_Overflow = 1: the write still occurs (o_WE = 1) and the instruction retires; go to HALT.
  - HALT: o_Halt = 1, o_Ready = 0. i_Clear → IDLE, clearing o_Illegal and o_OvfSticky.
- Throughput: 1 instruction per 2 cycles. No hazards, since the regfile write completes before the next EXEC read.
- i_Clear outside HALT clears o_OvfSticky only. i_Clear in the same cycle as an overflow capture: the clear wins for sticky, and o_Ovf still captures.
- o_Retired wraps modulo 2^CNT_W silently.
- Reset:
  - State IDLE; IR = 0.
  - All outputs 0 except o_Ready = 1.
  - Reset mid-EXEC aborts the instruction: no retire, no flag update. The regfile reset has priority over the pending write.
  - i_RST has priority over i_Clear and the handshake.

Decomposition:
- Shared package datapath_pkg holds:
  - opcode constants;
  - field bit positions (OP_HI/LO, RD_HI/LO, RS_HI/LO, RT_HI/LO, IMM_HI/LO);
  - the state encoding (IDLE/EXEC/HALT).
- One natural sub-module, instr_decode: combinational IR → fields, ALUSrc, AddSub, writes, is_arith, illegal.
- The FSM, counters and flags stay in datapath1_ctrl.

Test Plan:
1. Reset, then i_Instr = 0x60610005 (ADDI r3, r1, 5) with i_Valid. Next cycle must show o_WE = 1, o_WA = 3, o_RA0 = 1, o_ALUSrc = 1, o_AddSub = 0, o_Im = 0x0005. Then o_Retired = 1 and o_Ready = 1.
2. i_Instr = 0x40822800 (SUB r4, r2, r5) with i_Overflow = 1 in EXEC and TRAP_ON_OVF = 1. Required: o_WE = 1, o_AddSub = 1, o_RA1 = 5; then o_Ovf = 1, o_OvfSticky = 1, o_Halt = 1, o_Ready = 0. i_Clear → IDLE with o_OvfSticky = 0.
3. i_Instr = 0xE0000000 (illegal) → o_WE stays 0, then o_Halt = 1, o_Illegal = 1, o_Retired unchanged. Further i_Valid is ignored until i_Clear.
4. i_Valid held high with 4 instructions (ADD, NOP, ADDI, SUBI) → accepted every 2nd cycle. o_WE pulses 3 times; o_Retired = 4 after 8 cycles. The NOP leaves o_Carry unchanged.
5. CNT_W = 4 with 16 NOPs → o_Retired wraps to 0, with no halt.
6. Assert i_RST during EXEC of ADD → next cycle: state IDLE, o_Retired = 0, flags 0, o_Ready = 1, o_WE = 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath1 issue controller: instruction field
// layout, opcode values, FSM state encoding and the decoded-instruction bundle.
package datapath_pkg;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 29;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int OP_W  = OP_HI - OP_LO + 1;
  localparam int REG_W = RD_HI - RD_LO + 1;
  localparam int IMM_W = IMM_HI - IMM_LO + 1;

  // Opcodes; 3'b101..3'b111 are illegal
  localparam logic [OP_W-1:0] OPC_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OPC_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OPC_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OPC_ADDI = 3'b011;
  localparam logic [OP_W-1:0] OPC_SUBI = 3'b100;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Everything the controller needs to know about the instruction in IR
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [IMM_W-1:0] imm;
    logic             alu_src;
    logic             add_sub;
    logic             writes;
    logic             is_arith;
    logic             illegal;
  } dec_t;

  // True for the four arithmetic opcodes (ADD/SUB/ADDI/SUBI)
  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == OPC_ADD) || (op == OPC_SUB) ||
           (op == OPC_ADDI) || (op == OPC_SUBI);
  endfunction

endpackage

// File: rtl/datapath1_ctrl_instr_decode.sv
// Purely combinational decode of the instruction register into datapath
// control fields and classification bits.
module instr_decode
  import datapath_pkg::*;
(
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [OP_W-1:0] op;
  logic            unused_bits;

  assign op          = ir_i[OP_HI:OP_LO];
  // Bits [28:26] carry no meaning in this instruction format.
  assign unused_bits = ^ir_i[28:26];

  // Field extraction plus opcode classification
  always_comb begin
    dec_o          = '0;
    dec_o.rd       = ir_i[RD_HI:RD_LO];
    dec_o.rs       = ir_i[RS_HI:RS_LO];
    dec_o.rt       = ir_i[RT_HI:RT_LO];
    dec_o.imm      = ir_i[IMM_HI:IMM_LO];
    dec_o.is_arith = op_is_arith(op);
    // Every arithmetic instruction writes rd; NOP and illegal ones never do.
    dec_o.writes   = dec_o.is_arith;
    dec_o.illegal  = !dec_o.is_arith && (op != OPC_NOP);
    case (op)
      OPC_ADD:  begin dec_o.alu_src = 1'b0; dec_o.add_sub = 1'b0; end
      OPC_SUB:  begin dec_o.alu_src = 1'b0; dec_o.add_sub = 1'b1; end
      OPC_ADDI: begin dec_o.alu_src = 1'b1; dec_o.add_sub = 1'b0; end
      OPC_SUBI: begin dec_o.alu_src = 1'b1; dec_o.add_sub = 1'b1; end
      default:  begin dec_o.alu_src = 1'b0; dec_o.add_sub = 1'b0; end
    endcase
  end

endmodule

// File: rtl/datapath1_ctrl.sv
// Instruction issue controller for datapath1: accepts instructions over a
// valid/ready handshake, holds them in IR for a single EXEC cycle while the
// datapath computes, captures carry/overflow status, and halts on illegal
// opcodes or (optionally) on arithmetic overflow.
module datapath1_ctrl
  import datapath_pkg::*;
#(
  parameter bit TRAP_ON_OVF = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [31:0]      i_Instr,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic             i_Clear,
  input  logic             i_Cout,
  input  logic             i_Overflow,
  output logic [4:0]       o_RA0,
  output logic [4:0]       o_RA1,
  output logic [4:0]       o_WA,
  output logic [15:0]      o_Im,
  output logic             o_ALUSrc,
  output logic             o_AddSub,
  output logic             o_WE,
  output logic             o_Carry,
  output logic             o_Ovf,
  output logic             o_OvfSticky,
  output logic             o_Halt,
  output logic             o_Illegal,
  output logic [CNT_W-1:0] o_Retired
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  dec_t             dec;
  logic             in_exec;
  logic             accept;
  logic             ovf_trap;

  instr_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign in_exec  = (state_q == ST_EXEC);
  assign accept   = (state_q == ST_IDLE) && i_Valid;
  assign ovf_trap = TRAP_ON_OVF && dec.is_arith && i_Overflow;

  // Decoded datapath controls come straight from IR in every state
  always_comb begin
    o_RA0    = dec.rs;
    o_RA1    = dec.rt;
    o_WA     = dec.rd;
    o_Im     = dec.imm;
    o_ALUSrc = dec.alu_src;
    o_AddSub = dec.add_sub;
  end

  // FSM next-state and state-derived outputs
  always_comb begin
    state_d = state_q;
    o_Ready = 1'b0;
    o_WE    = 1'b0;
    o_Halt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // An overflow trap still lets the faulting write land.
        o_WE = dec.writes && !dec.illegal;
        if (dec.illegal || ovf_trap) state_d = ST_HALT;
        else                         state_d = ST_IDLE;
      end
      ST_HALT: begin
        o_Halt = 1'b1;
        if (i_Clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IR, status flags and retire counter next-state
  always_comb begin
    ir_d      = ir_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    sticky_d  = sticky_q;
    illegal_d = illegal_q;
    retired_d = retired_q;

    if (accept) ir_d = i_Instr;

    if (in_exec && !dec.illegal) retired_d = retired_q + CNT_W'(1);

    if (in_exec && dec.is_arith) begin
      carry_d  = i_Cout;
      ovf_d    = i_Overflow;
      sticky_d = sticky_q | i_Overflow;
    end

    if (in_exec && dec.illegal) illegal_d = 1'b1;

    // Clear always wins over a same-cycle overflow for the sticky bit; it
    // only drops the illegal marker when leaving HALT.
    if (i_Clear) sticky_d = 1'b0;
    if ((state_q == ST_HALT) && i_Clear) illegal_d = 1'b0;
  end

  // State and register update; reset aborts any in-flight instruction
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign o_Carry     = carry_q;
  assign o_Ovf       = ovf_q;
  assign o_OvfSticky = sticky_q;
  assign o_Illegal   = illegal_q;
  assign o_Retired   = retired_q;

endmodule

// File: tb/tb_datapath1_ctrl.sv
// Directed plus randomized bench for datapath1_ctrl. A transaction-level
// model tracks expected flags/counters per instruction; a second instance
// with a 4-bit retire counter checks wrap-around on the same stimulus.
module tb_datapath1_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid, clear, cout, ovf;

  logic        ready, alusrc, addsub, we, carry, ovf_o, sticky, halt, illegal;
  logic [4:0]  ra0, ra1, wa;
  logic [15:0] im;
  logic [15:0] retired;

  logic        ready4, alusrc4, addsub4, we4, carry4, ovf4, sticky4, halt4, illegal4;
  logic [4:0]  ra04, ra14, wa4;
  logic [15:0] im4;
  logic [3:0]  retired4;

  int passed = 0;
  int total  = 0;

  // Model state
  bit m_halt, m_illegal, m_carry, m_ovf, m_sticky;
  int m_retired;

  always #5 clk = ~clk;

  datapath1_ctrl #(.TRAP_ON_OVF(1'b1), .CNT_W(16)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Instr(instr), .i_Valid(valid), .o_Ready(ready),
    .i_Clear(clear), .i_Cout(cout), .i_Overflow(ovf),
    .o_RA0(ra0), .o_RA1(ra1), .o_WA(wa), .o_Im(im), .o_ALUSrc(alusrc),
    .o_AddSub(addsub), .o_WE(we), .o_Carry(carry), .o_Ovf(ovf_o),
    .o_OvfSticky(sticky), .o_Halt(halt), .o_Illegal(illegal), .o_Retired(retired)
  );

  datapath1_ctrl #(.TRAP_ON_OVF(1'b1), .CNT_W(4)) dut4 (
    .i_CLK(clk), .i_RST(rst), .i_Instr(instr), .i_Valid(valid), .o_Ready(ready4),
    .i_Clear(clear), .i_Cout(cout), .i_Overflow(ovf),
    .o_RA0(ra04), .o_RA1(ra14), .o_WA(wa4), .o_Im(im4), .o_ALUSrc(alusrc4),
    .o_AddSub(addsub4), .o_WE(we4), .o_Carry(carry4), .o_Ovf(ovf4),
    .o_OvfSticky(sticky4), .o_Halt(halt4), .o_Illegal(illegal4), .o_Retired(retired4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".halt"},     32'(halt),     32'(m_halt));
    chk({tag, ".illegal"},  32'(illegal),  32'(m_illegal));
    chk({tag, ".carry"},    32'(carry),    32'(m_carry));
    chk({tag, ".ovf"},      32'(ovf_o),    32'(m_ovf));
    chk({tag, ".sticky"},   32'(sticky),   32'(m_sticky));
    chk({tag, ".retired"},  32'(retired),  32'(m_retired % 65536));
    chk({tag, ".retired4"}, 32'(retired4), 32'(m_retired % 16));
    chk({tag, ".ready"},    32'(ready),    32'(!m_halt));
    chk({tag, ".we_idle"},  32'(we),       32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; clear = 1'b0; cout = 1'b0; ovf = 1'b0; instr = '0;
    step(); step();
    rst = 1'b0;
    m_halt = 0; m_illegal = 0; m_carry = 0; m_ovf = 0; m_sticky = 0; m_retired = 0;
  endtask

  // Issue one instruction from IDLE: accept edge, then EXEC closing edge.
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input bit v_ovf, input bit v_cout, input bit v_clr,
                           input bit hold);
    int  op;
    bit  legal, arith;
    op    = int'(ins >> 29);
    legal = (op <= 4);
    arith = (op >= 1) && (op <= 4);
    instr = ins; valid = 1'b1;
    step();
    // Now in EXEC: decoded fields reflect the accepted instruction
    chk({tag, ".x_ready"}, 32'(ready), 32'(0));
    chk({tag, ".x_we"},    32'(we),    32'(arith));
    chk({tag, ".x_wa"},    32'(wa),    (ins >> 21) & 32'h1f);
    chk({tag, ".x_ra0"},   32'(ra0),   (ins >> 16) & 32'h1f);
    chk({tag, ".x_ra1"},   32'(ra1),   (ins >> 11) & 32'h1f);
    chk({tag, ".x_im"},    32'(im),    ins & 32'hffff);
    chk({tag, ".x_alusrc"}, 32'(alusrc), 32'(op == 3 || op == 4));
    chk({tag, ".x_addsub"}, 32'(addsub), 32'(op == 2 || op == 4));
    valid = hold; ovf = v_ovf; cout = v_cout; clear = v_clr;
    step();
    ovf = 1'b0; cout = 1'b0; clear = 1'b0;
    if (legal) m_retired++;
    if (arith) begin m_carry = v_cout; m_ovf = v_ovf; m_sticky = m_sticky | v_ovf; end
    if (v_clr) m_sticky = 0;
    if (!legal) begin m_halt = 1; m_illegal = 1; end
    else if (arith && v_ovf) m_halt = 1;
    chk_status(tag);
  endtask

  task automatic clear_halt(input string tag);
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_halt = 0; m_illegal = 0; m_sticky = 0;
    chk_status(tag);
  endtask

  initial begin
    logic [31:0] r;
    int          op;

    // Reset state
    do_reset();
    chk_status("rst");
    chk("rst.wa",  32'(wa),  32'(0));
    chk("rst.im",  32'(im),  32'(0));
    chk("rst.ra0", 32'(ra0), 32'(0));

    // 1: ADDI r3, r1, 5
    run_instr("addi", 32'h60610005, 0, 1, 0, 0);

    // 2: SUB r4, r2, r5 with overflow traps
    run_instr("subovf", 32'h40822800, 1, 0, 0, 0);
    clear_halt("subclr");

    // 3: illegal opcode; handshake ignored while halted
    run_instr("illegal", 32'hE0000000, 0, 0, 0, 0);
    instr = 32'h20000000; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_status("haltvalid");
    end
    valid = 1'b0;
    clear_halt("illclr");

    // 4: back-to-back with valid held high: ADD(carry=1), NOP, ADDI, SUBI
    begin
      int base;
      base = m_retired;
      run_instr("b2b_add",  32'h20221800, 0, 1, 0, 1);
      run_instr("b2b_nop",  32'h00000000, 0, 0, 0, 1);
      run_instr("b2b_addi", 32'h60a3ffff, 0, 1, 0, 1);
      run_instr("b2b_subi", 32'h80c40010, 0, 0, 0, 0);
      chk("b2b.delta", 32'(m_retired - base), 32'(4));
    end

    // Clear outside HALT only drops the sticky bit
    run_instr("ovf_notrap_setup", 32'h20000000, 1, 1, 0, 0);
    clear_halt("ovf_c1");
    run_instr("stk_set", 32'h20000000, 0, 0, 0, 0);
    run_instr("clr_wins", 32'h40000000, 1, 1, 1, 0);
    clear_halt("clrw_c");

    // 5: 16 NOPs after reset wrap the 4-bit counter to 0
    do_reset();
    for (int i = 0; i < 16; i++) run_instr("nop16", 32'h00000000, 1, 1, 0, 1);
    valid = 1'b0;
    chk("wrap4", 32'(retired4), 32'(0));
    chk("wrap16", 32'(retired), 32'(16));

    // 6: reset during EXEC of ADD
    instr = 32'h20221800; valid = 1'b1;
    step();
    chk("rstx.we_pre", 32'(we), 32'(1));
    rst = 1'b1; ovf = 1'b1; cout = 1'b1; valid = 1'b0;
    step();
    rst = 1'b0; ovf = 1'b0; cout = 1'b0;
    m_halt = 0; m_illegal = 0; m_carry = 0; m_ovf = 0; m_sticky = 0; m_retired = 0;
    chk_status("rstx");

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      r  = $urandom;
      op = int'($urandom_range(0, 7));
      if (op > 4 && ($urandom_range(0, 2) != 0)) op = op - 4;
      r[31:29] = 3'(op);
      run_instr("rand", r, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
      valid = 1'b0;
      if (m_halt) clear_halt("randclr");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
